// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage PC sequencer with redirect, stall and interrupt vector entry
//
// Purpose:
//   Owns the program counter and drives the instruction memory address.
//   Each edge it chooses the next PC from one of four sources:
//     - sequential increment
//     - stall hold
//     - branch/jump redirect
//     - interrupt entry
//   Interrupt entry reads a 32-bit handler address from two reserved words.
//   It reads the high half at INT_VEC_ADDR and the low half at INT_VEC_ADDR+1.
//   It then loads that address into the PC.
//
// Parameters:
//   RESET_PC      PC loaded on reset; lower words are reserved for vectors
//   INT_VEC_ADDR  word address of the handler vector high half
//
// Ports:
//   clk            clock, all state updates on posedge
//   rst            asynchronous active-high reset
//   stall          hold request from decode/hazard logic
//   redirect_valid taken branch/jump/return this cycle
//   redirect_pc    redirect target PC
//   irq            level interrupt request, held until int_ack
//   imem_data      instruction memory data for imem_addr (same cycle)
//   imem_addr      instruction memory word address
//   instr          registered fetched instruction
//   pc_out         PC of instr
//   instr_valid    instr/pc_out hold a real instruction (0 = bubble)
//   ret_pc         PC to resume after the interrupt
//   int_ack        one-cycle pulse when the handler PC is loaded
//   busy           high while the interrupt sequence is running

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0020,
  parameter logic [19:0] INT_VEC_ADDR = 20'h0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        irq,
  input  logic [15:0] imem_data,
  output logic [19:0] imem_addr,
  output logic [15:0] instr,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic [31:0] ret_pc,
  output logic        int_ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    INT_HI = 2'd1,
    INT_LO = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [15:0] vec_hi;

  // The address is decoded straight from registers.
  // A reset mid-sequence therefore shows RESET_PC on the bus immediately.
  always_comb begin
    imem_addr = pc[19:0];
    case (state)
      INT_HI:  imem_addr = INT_VEC_ADDR;
      INT_LO:  imem_addr = INT_VEC_ADDR + 20'd1;
      default: imem_addr = pc[19:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      vec_hi      <= 16'h0000;
      instr       <= 16'h0000;
      pc_out      <= 32'h0000_0000;
      instr_valid <= 1'b0;
      ret_pc      <= 32'h0000_0000;
      int_ack     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // int_ack is a single-cycle pulse.
      // Only the INT_LO branch below sets it.
      int_ack <= 1'b0;
      case (state)
        RUN: begin
          if (redirect_valid) begin
            // A redirect wins over stall and irq.
            // A pending irq stays pending and is taken afterwards.
            // Its return address is then the redirect target.
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
          end else if (irq && !stall) begin
            // The word at pc is not fetched.
            // It becomes the resume point instead.
            ret_pc      <= pc;
            instr_valid <= 1'b0;
            busy        <= 1'b1;
            state       <= INT_HI;
          end else if (stall) begin
            // Everything holds.
            // A deferred irq is re-evaluated once stall drops.
            pc          <= pc;
          end else begin
            instr       <= imem_data;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd1;
          end
        end

        INT_HI: begin
          // redirect/stall/irq are ignored for the whole vector fetch.
          vec_hi <= imem_data;
          state  <= INT_LO;
        end

        INT_LO: begin
          // The vector is not range-checked.
          // A handler inside the reserved region is allowed.
          pc      <= {vec_hi, imem_data};
          int_ack <= 1'b1;
          busy    <= 1'b0;
          state   <= RUN;
        end

        default: begin
          busy  <= 1'b0;
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - vector table plus scoreboard bench for fetch_ctrl

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        irq = 1'b0;
  logic [15:0] imem_data;
  logic [19:0] imem_addr;
  logic [15:0] instr;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic [31:0] ret_pc;
  logic        int_ack;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory contents.
  // The vector words are mem[0]=0x0000 and mem[1]=0x0400.
  // Every other word holds a distinct pattern.
  function automatic logic [15:0] memf(input logic [19:0] a);
    if (a == 20'h0) return 16'h0000;
    if (a == 20'h1) return 16'h0400;
    return a[15:0] * 16'd7 + 16'h1234;
  endfunction

  assign imem_data = memf(imem_addr);

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .irq            (irq),
    .imem_data      (imem_data),
    .imem_addr      (imem_addr),
    .instr          (instr),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .ret_pc         (ret_pc),
    .int_ack        (int_ack),
    .busy           (busy)
  );

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        irq;
    logic        v;
    logic [31:0] pc;
    logic [31:0] ret;
    logic        busy;
    logic        ack;
  } vec_t;

  vec_t tbl[31];
  vec_t sb[$];

  function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] rpc,
                              input logic i, input logic v, input logic [31:0] pc,
                              input logic [31:0] ret, input logic b, input logic a);
    vec_t r;
    r.stall = s;
    r.rv    = rv;
    r.rpc   = rpc;
    r.irq   = i;
    r.v     = v;
    r.pc    = pc;
    r.ret   = ret;
    r.busy  = b;
    r.ack   = a;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  initial begin
    // Each row is {stall, redirect_valid, redirect_pc, irq}.
    // It is followed by the outputs expected after that edge: {valid, pc_out, ret_pc, busy, int_ack}.
    tbl[0]  = mk(0,0,0,0,        1,32'h20,0,0,0);
    tbl[1]  = mk(1,0,0,0,        1,32'h20,0,0,0);
    tbl[2]  = mk(1,0,0,0,        1,32'h20,0,0,0);
    tbl[3]  = mk(1,0,0,0,        1,32'h20,0,0,0);
    tbl[4]  = mk(0,0,0,0,        1,32'h21,0,0,0);
    tbl[5]  = mk(0,0,0,0,        1,32'h22,0,0,0);
    tbl[6]  = mk(1,1,32'h100,0,  0,32'h0,0,0,0);
    tbl[7]  = mk(0,0,0,0,        1,32'h100,0,0,0);
    tbl[8]  = mk(0,0,0,0,        1,32'h101,0,0,0);
    tbl[9]  = mk(0,1,32'h24,0,   0,32'h0,0,0,0);
    tbl[10] = mk(0,0,0,0,        1,32'h24,0,0,0);
    tbl[11] = mk(0,0,0,1,        0,32'h0,32'h25,1,0);
    tbl[12] = mk(1,0,0,1,        0,32'h0,32'h25,1,0);
    tbl[13] = mk(0,1,32'h300,1,  0,32'h0,32'h25,0,1);
    tbl[14] = mk(0,0,0,0,        1,32'h400,32'h25,0,0);
    tbl[15] = mk(0,0,0,0,        1,32'h401,32'h25,0,0);
    tbl[16] = mk(0,1,32'h80,1,   0,32'h0,32'h25,0,0);
    tbl[17] = mk(0,0,0,1,        0,32'h0,32'h80,1,0);
    tbl[18] = mk(0,0,0,1,        0,32'h0,32'h80,1,0);
    tbl[19] = mk(0,1,32'h300,1,  0,32'h0,32'h80,0,1);
    tbl[20] = mk(0,0,0,0,        1,32'h400,32'h80,0,0);
    tbl[21] = mk(1,0,0,1,        1,32'h400,32'h80,0,0);
    tbl[22] = mk(1,0,0,1,        1,32'h400,32'h80,0,0);
    tbl[23] = mk(0,0,0,1,        0,32'h0,32'h401,1,0);
    tbl[24] = mk(0,0,0,1,        0,32'h0,32'h401,1,0);
    tbl[25] = mk(0,0,0,1,        0,32'h0,32'h401,0,1);
    tbl[26] = mk(0,0,0,0,        1,32'h400,32'h401,0,0);
    tbl[27] = mk(0,0,0,0,        1,32'h401,32'h401,0,0);
    tbl[28] = mk(0,1,32'hFFFF_FFFF,0, 0,32'h0,32'h401,0,0);
    tbl[29] = mk(0,0,0,0,        1,32'hFFFF_FFFF,32'h401,0,0);
    tbl[30] = mk(0,0,0,0,        1,32'h0,32'h401,0,0);

    // Reset state.
    #12;
    chk("rst_addr",  {12'h0, imem_addr}, 32'h20);
    chk("rst_instr", {16'h0, instr}, 32'h0);
    chk("rst_pcout", pc_out, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_ret",   ret_pc, 32'h0);
    chk("rst_ack",   {31'h0, int_ack}, 32'h0);
    chk("rst_busy",  {31'h0, busy}, 32'h0);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 31; i++) begin
      if (i != 0) @(negedge clk);
      stall          = tbl[i].stall;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      irq            = tbl[i].irq;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty row %0d: got 0 entries required 1", i);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk($sformatf("valid[%0d]", i), {31'h0, instr_valid}, {31'h0, e.v});
        chk($sformatf("busy[%0d]", i),  {31'h0, busy}, {31'h0, e.busy});
        chk($sformatf("ack[%0d]", i),   {31'h0, int_ack}, {31'h0, e.ack});
        chk($sformatf("ret[%0d]", i),   ret_pc, e.ret);
        if (e.v) begin
          chk($sformatf("pc_out[%0d]", i), pc_out, e.pc);
          chk($sformatf("instr[%0d]", i), {16'h0, instr}, {16'h0, memf(e.pc[19:0])});
        end
      end
    end

    // Vector-address sequencing.
    // INT_LO reads the low word, and the ack cycle presents the handler.
    @(negedge clk);
    stall = 1'b0;
    redirect_valid = 1'b0;
    irq = 1'b1;
    @(posedge clk);
    #1;
    chk("hi_addr", {12'h0, imem_addr}, 32'h0);
    @(posedge clk);
    #1;
    chk("lo_addr", {12'h0, imem_addr}, 32'h1);
    @(posedge clk);
    #1;
    chk("ack_addr", {12'h0, imem_addr}, 32'h400);
    chk("ack_pulse", {31'h0, int_ack}, 32'h1);
    @(negedge clk);
    irq = 1'b0;

    // Asynchronous reset during INT_HI.
    irq = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_busy_pre", {31'h0, busy}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy",  {31'h0, busy}, 32'h0);
    chk("ar_addr",  {12'h0, imem_addr}, 32'h20);
    chk("ar_valid", {31'h0, instr_valid}, 32'h0);
    chk("ar_instr", {16'h0, instr}, 32'h0);
    chk("ar_pcout", pc_out, 32'h0);
    chk("ar_ret",   ret_pc, 32'h0);
    chk("ar_ack",   {31'h0, int_ack}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    irq = 1'b0;
    @(posedge clk);
    #1;
    chk("ar_refetch_pc",    pc_out, 32'h20);
    chk("ar_refetch_valid", {31'h0, instr_valid}, 32'h1);
    chk("ar_refetch_instr", {16'h0, instr}, {16'h0, memf(20'h20)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
